sdram_host_arb: RTL and testbench

SDRAM_HOST_ARB -- requirements
Module: sdram_host_arb

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_arb_rr.sv | 35 +++
 rtl/sdram_host_arb.sv | 170 +++++++++++++++++
 tb/tb_sdram_host_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants, FSM state type and small helpers for the two-requester SDRAM host arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;
  localparam int WAIT_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_onehot(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin grant selection; purely combinational.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  // A lone requester wins; under contention the one not served last wins.
  always_comb begin
    grant_o = 1'b0;
    valid_o = 1'b0;
    case (req_i)
      2'b01: begin
        grant_o = 1'b0;
        valid_o = 1'b1;
      end
      2'b10: begin
        grant_o = 1'b1;
        valid_o = 1'b1;
      end
      2'b11: begin
        grant_o = ~last_grant_i;
        valid_o = 1'b1;
      end
      default: begin
        grant_o = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sdram_host_arb.sv
// Arbitrates two host requesters onto one SDRAM controller command port,
// with a bounded wait for the controller's completion pulse.
module sdram_host_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          ack_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                host_rd_o,
  output logic                host_wr_o,
  output logic [ADDR_W-1:0]   host_addr_o,
  output logic [DATA_W-1:0]   host_data_o,
  input  logic [DATA_W-1:0]   host_data_i,
  input  logic                host_done_i
);

  localparam logic [WAIT_CNT_W-1:0] TMO_V = WAIT_CNT_W'(TMO_CYC);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     hdata_q, hdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  rr_gnt_s;
  logic                  rr_vld_s;
  logic                  sel_we_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic [WAIT_CNT_W-1:0] cnt_inc_s;
  logic                  tmo_s;

  sdram_arb_rr u_rr (
    .req_i        (req_i),
    .last_grant_i (last_q),
    .grant_o      (rr_gnt_s),
    .valid_o      (rr_vld_s)
  );

  // Route the winning requester's command fields toward the latch.
  always_comb begin
    if (rr_gnt_s) begin
      sel_we_s    = we_i[1];
      sel_addr_s  = addr_i[ADDR_W +: ADDR_W];
      sel_wdata_s = wdata_i[DATA_W +: DATA_W];
    end else begin
      sel_we_s    = we_i[0];
      sel_addr_s  = addr_i[0 +: ADDR_W];
      sel_wdata_s = wdata_i[0 +: DATA_W];
    end
  end

  // The counter holds completed BUSY cycles minus one, so the check uses the incremented value.
  assign cnt_inc_s = cnt_q + 8'd1;
  assign tmo_s     = (cnt_inc_s == TMO_V);

  // Next-state, command and completion logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    hdata_d = hdata_q;
    rdata_d = rdata_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld_s) begin
          state_d = ST_BUSY;
          gnt_d   = rr_gnt_s;
          last_d  = rr_gnt_s;
          cnt_d   = 8'd0;
          rd_d    = ~sel_we_s;
          wr_d    = sel_we_s;
          addr_d  = sel_addr_s;
          hdata_d = sel_wdata_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (host_done_i) begin
          state_d = ST_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = grant_onehot(gnt_q);
          if (rd_q) begin
            rdata_d = host_data_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (tmo_s) begin
          state_d = ST_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = grant_onehot(gnt_q);
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      hdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      hdata_q <= hdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign host_rd_o   = rd_q;
  assign host_wr_o   = wr_q;
  assign host_addr_o = addr_q;
  assign host_data_o = hdata_q;

endmodule

// File: tb/tb_sdram_host_arb.sv
// Randomized self-checking bench for sdram_host_arb against a transaction-level reference model.
module tb_sdram_host_arb;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              reset_l;
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [2*AW-1:0]   addr_i;
  logic [2*DW-1:0]   wdata_i;
  logic [1:0]        ack_o;
  logic              err_o;
  logic [DW-1:0]     rdata_o;
  logic              host_rd_o;
  logic              host_wr_o;
  logic [AW-1:0]     host_addr_o;
  logic [DW-1:0]     host_data_o;
  logic [DW-1:0]     host_data_i;
  logic              host_done_i;

  int                err_cnt = 0;
  int                chk_cnt = 0;
  logic              model_last;
  logic [DW-1:0]     model_rdata;
  logic              mon_en = 1'b0;
  logic [1:0]        ack_seen;
  logic [1:0]        rr_exp [4];

  sdram_host_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .host_rd_o   (host_rd_o),
    .host_wr_o   (host_wr_o),
    .host_addr_o (host_addr_o),
    .host_data_o (host_data_o),
    .host_data_i (host_data_i),
    .host_done_i (host_done_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read and write commands must never be asserted together.
  always @(negedge clk) begin
    if (mon_en) check_val("cmd_onehot", 64'(host_rd_o & host_wr_o), 64'd0);
  end

  // Round-robin rule: lone requester wins, otherwise the one not served last.
  function automatic logic model_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return !last;
    return r[1];
  endfunction

  task automatic set_req(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[n]             = 1'b1;
    we_i[n]              = we;
    addr_i[n*AW +: AW]   = a;
    wdata_i[n*DW +: DW]  = d;
  endtask

  // Called at a negedge with the DUT idle and requests applied; returns at the negedge of the following idle cycle.
  task automatic run_txn(input int done_at, input bit scramble, input logic [DW-1:0] rd_data,
                         output logic [1:0] ack_obs);
    logic          g;
    int            gi;
    int            oi;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eerr;
    int            n_exp;
    g           = model_pick(req_i, model_last);
    model_last  = g;
    gi          = g ? 1 : 0;
    oi          = 1 - gi;
    ewe         = we_i[gi];
    ea          = addr_i[gi*AW +: AW];
    ed          = wdata_i[gi*DW +: DW];
    eerr        = !(done_at >= 1 && done_at <= TMO);
    n_exp       = eerr ? TMO : done_at;
    host_done_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int k = 1; k <= n_exp; k++) begin
      @(negedge clk);
      check_val("busy_rd",   64'(host_rd_o),   64'(!ewe));
      check_val("busy_wr",   64'(host_wr_o),   64'(ewe));
      check_val("busy_addr", 64'(host_addr_o), 64'(ea));
      check_val("busy_data", 64'(host_data_o), 64'(ed));
      check_val("busy_ack",  64'(ack_o),       64'd0);
      host_done_i = (k == done_at);
      host_data_i = (k == done_at) ? rd_data : DW'($urandom);
      if (k == done_at && !ewe) model_rdata = rd_data;
      if (scramble) begin
        req_i[oi]             = 1'($urandom_range(0, 1));
        we_i[oi]              = 1'($urandom_range(0, 1));
        addr_i[oi*AW +: AW]   = AW'($urandom);
        wdata_i[oi*DW +: DW]  = DW'($urandom);
      end
    end
    @(negedge clk);
    ack_obs = ack_o;
    check_val("done_rd",    64'(host_rd_o), 64'd0);
    check_val("done_wr",    64'(host_wr_o), 64'd0);
    check_val("done_ack",   64'(ack_o),     g ? 64'd2 : 64'd1);
    check_val("done_err",   64'(err_o),     64'(eerr));
    check_val("done_rdata", 64'(rdata_o),   64'(model_rdata));
    req_i[gi]   = 1'b0;
    host_done_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("idle_ack",   64'(ack_o),     64'd0);
    check_val("idle_err",   64'(err_o),     64'd0);
    check_val("idle_cmd",   64'(host_rd_o | host_wr_o), 64'd0);
    check_val("idle_rdata", 64'(rdata_o),   64'(model_rdata));
    host_done_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l     = 1'b0;
    req_i       = 2'b00;
    host_done_i = 1'b0;
    @(negedge clk);
    reset_l     = 1'b1;
    model_last  = 1'b1;
    model_rdata = '0;
  endtask

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    reset_l     = 1'b0;
    req_i       = 2'b00;
    we_i        = 2'b00;
    addr_i      = '0;
    wdata_i     = '0;
    host_data_i = '0;
    host_done_i = 1'b0;
    model_last  = 1'b1;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack",   64'(ack_o),       64'd0);
    check_val("rst_err",   64'(err_o),       64'd0);
    check_val("rst_rd",    64'(host_rd_o),   64'd0);
    check_val("rst_wr",    64'(host_wr_o),   64'd0);
    check_val("rst_addr",  64'(host_addr_o), 64'd0);
    check_val("rst_data",  64'(host_data_o), 64'd0);
    check_val("rst_rdata", 64'(rdata_o),     64'd0);
    reset_l = 1'b1;
    mon_en  = 1'b1;

    // Single read from requester 0, done on the fourth busy cycle.
    set_req(0, 1'b0, 24'h000123, 16'h0000);
    run_txn(4, 1'b0, 16'hBEEF, ack_seen);
    check_val("read_ack", 64'(ack_seen), 64'd1);
    check_val("read_rdata", 64'(rdata_o), 64'hBEEF);

    // Write from requester 1 leaves read data untouched.
    req_i = 2'b00;
    set_req(1, 1'b1, 24'hFFFFFF, 16'hA5A5);
    run_txn(2, 1'b0, 16'h1111, ack_seen);
    check_val("write_ack", 64'(ack_seen), 64'd2);
    check_val("write_rdata", 64'(rdata_o), 64'hBEEF);

    // Both requesters held from reset alternate 0,1,0,1.
    do_reset();
    set_req(0, 1'b0, 24'h000AAA, 16'h0A0A);
    set_req(1, 1'b1, 24'h000BBB, 16'h0B0B);
    for (int i = 0; i < 4; i++) begin
      req_i = 2'b11;
      run_txn(3, 1'b0, DW'($urandom), ack_seen);
      check_val("rr_order", 64'(ack_seen), 64'(rr_exp[i]));
    end

    // Timeout with no completion, then completion landing exactly on the timeout cycle.
    req_i = 2'b00;
    set_req(0, 1'b0, 24'h123456, 16'h0000);
    run_txn(0, 1'b0, 16'hDEAD, ack_seen);
    req_i = 2'b00;
    set_req(1, 1'b0, 24'h654321, 16'h0000);
    run_txn(TMO, 1'b0, 16'h5A3C, ack_seen);
    check_val("tmo_edge_rdata", 64'(rdata_o), 64'h5A3C);

    // Reset in the middle of an access aborts without ack and restores the pointer.
    req_i = 2'b00;
    set_req(0, 1'b0, 24'h0ABCDE, 16'h1234);
    @(posedge clk);
    @(negedge clk);
    check_val("abort_busy_rd", 64'(host_rd_o), 64'd1);
    @(negedge clk);
    reset_l = 1'b0;
    @(negedge clk);
    check_val("abort_rd",    64'(host_rd_o),   64'd0);
    check_val("abort_wr",    64'(host_wr_o),   64'd0);
    check_val("abort_ack",   64'(ack_o),       64'd0);
    check_val("abort_err",   64'(err_o),       64'd0);
    check_val("abort_addr",  64'(host_addr_o), 64'd0);
    check_val("abort_data",  64'(host_data_o), 64'd0);
    check_val("abort_rdata", 64'(rdata_o),     64'd0);
    reset_l     = 1'b1;
    req_i       = 2'b00;
    model_last  = 1'b1;
    model_rdata = '0;
    for (int i = 0; i < TMO + 2; i++) begin
      @(negedge clk);
      check_val("abort_no_ack", 64'(ack_o), 64'd0);
    end
    set_req(0, 1'b1, 24'h000010, 16'h0101);
    set_req(1, 1'b1, 24'h000020, 16'h0202);
    run_txn(2, 1'b0, 16'h0000, ack_seen);
    check_val("post_rst_grant", 64'(ack_seen), 64'd1);

    // Random traffic with disturbance on the idle requester while busy.
    for (int t = 0; t < 40; t++) begin
      req_i = 2'($urandom_range(1, 3));
      for (int n = 0; n < 2; n++) begin
        we_i[n]             = 1'($urandom_range(0, 1));
        addr_i[n*AW +: AW]  = AW'($urandom);
        wdata_i[n*DW +: DW] = DW'($urandom);
      end
      run_txn(int'($urandom_range(0, TMO + 2)), 1'b1, DW'($urandom), ack_seen);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
